subservient_sram_bridge: RTL and testbench
==========================================

Name: subservient_sram_bridge

Overview:
- Parametrised bridge between the subservient 8-bit byte-serial SRAM port and a wide dual-port (1 write port, 1 read port) SRAM macro.
- Holds a one-word read buffer so repeated byte reads of the same word hit without an SRAM access.
- Holds a one-word write-coalescing buffer that merges byte writes into a single masked word write.
- Adds a ready/valid handshake and configurable SRAM read latency.

Parameters:
- MEM_AW, 10: byte address width of the core side.
- SRAM_DW, 32: SRAM word width; legal values 32 or 64. Derived: BPW = SRAM_DW/8, LW = log2(BPW), WAW = MEM_AW-LW.
- RD_LAT, 1: SRAM read latency in cycles, 1 or 2.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_waddr  in  MEM_AW  byte write address
- i_wdata  in  8  byte write data
- i_wen  in  1  write request
- i_raddr  in  MEM_AW  byte read address
- i_ren  in  1  read request
- i_flush  in  1  request to write back the coalescing buffer
- o_ready  out  1  bridge can accept a request this cycle
- o_rdata  out  8  read byte
- o_rvalid  out  1  o_rdata valid, one-cycle pulse
- o_sram_waddr  out  WAW  SRAM write word address
- o_sram_wdata  out  SRAM_DW  SRAM write data; byte replicated or merged per lane
- o_sram_wmask  out  BPW  SRAM byte write mask
- o_sram_wen  out  1  SRAM write enable
- o_sram_raddr  out  WAW  SRAM read word address
- o_sram_ren  out  1  SRAM read enable
- i_sram_rdata  in  SRAM_DW  SRAM read data

Behaviour:
- Reset: the clock is i_clk; reset i_rst_n is asynchronous, active-low.
  - All o_sram_* outputs, o_rdata and o_rvalid reset to 0; o_ready resets to 1.
  - Read buffer and write buffer reset to invalid; FSM resets to IDLE.
- Arbitration: at most one request is accepted per cycle. Priority is write > flush > read.
  - A request is accepted iff o_ready=1 and no higher-priority request is asserted.
  - A request that is not accepted must be held by the requester.
- Address split: word = addr[MEM_AW-1:LW]; lane = addr[LW-1:0].
- All SRAM outputs are registered; each is asserted for exactly one cycle per access.
- Write accepted at cycle T:
  - Write buffer valid, different word: at T+1 the old buffer is written (o_sram_wen=1, mask and data from the buffer). The buffer is then reloaded with the new byte, mask = 1<<lane.
  - Write buffer valid, same word: the byte is merged and the mask bit is set; no SRAM access.
  - Write buffer invalid: the buffer is loaded; no SRAM access.
  - Read buffer valid and word matches: the read-buffer byte at that lane is updated at T+1.
  - o_ready stays 1.
- Flush accepted at T: if the write buffer is valid, it is written at T+1 and invalidated. An empty buffer makes the flush a no-op.
- Read accepted at T, read buffer hit: o_rdata = buffer byte and o_rvalid=1 at T+1; o_ready stays 1.
- Read accepted at T, miss: the FSM runs IDLE -> ISSUE -> WAIT(RD_LAT-1 cycles) -> FILL -> IDLE.
  - o_sram_ren=1 at T+1; o_ready=0 from T+1 through T+1+RD_LAT.
  - At T+1+RD_LAT, i_sram_rdata is captured into the read buffer.
  - Before capture, any write-buffer bytes of the same word (by mask) override the captured bytes.
  - o_rvalid=1 at T+2+RD_LAT, with o_ready back to 1.
- No write is accepted during ISSUE/WAIT/FILL, so the write buffer is stable for the merge. A read-during-write at the SRAM is therefore never observable.
- Full mask: a fully set write-buffer mask is not flushed automatically; it is flushed on the next differing write or i_flush.
- Word-address compares use WAW bits; no wrap handling is needed beyond address truncation.
- Reset during a miss: the FSM returns to IDLE, both buffers are invalidated, and no o_rvalid is produced.

Optional Feature:
- SUBSERVIENT_SRAM_WCOALESCE_EN defined: write buffer and merge logic as described above.
- Not defined: there is no write buffer. Each accepted write is issued at T+1 as o_sram_wen=1, o_sram_wmask=1<<lane, o_sram_wdata = byte replicated BPW times. i_flush is accepted and ignored. Read-buffer update on write is kept.

Test Plan:
- SRAM_DW=32, RD_LAT=1. Reset, read 0x004 with SRAM word 0x44332211 -> o_sram_ren at T+1, o_rvalid at T+3 with o_rdata=0x11. Read 0x006 -> hit, o_rvalid at T+1 with 0x33, no o_sram_ren.
- Coalescing: write 0xAA@0x010, 0xBB@0x011, then 0xCC@0x020 -> a single o_sram_wen with waddr=4, wmask=0011, wdata[15:0]=0xBBAA. Then i_flush -> waddr=8, wmask=0001.
- Merge: write 0x5A@0x031 with the buffer unflushed, then read 0x031 (miss, SRAM returns 0) -> o_rdata=0x5A.
- Priority: i_wen, i_flush and i_ren asserted together -> only the write is accepted. Holding flush and read -> flush next cycle, then read.
- RD_LAT=2, SRAM_DW=64: read miss at T -> o_ready=0 for T+1..T+3, o_rvalid at T+4.
- Drop i_rst_n at T+2 of a miss -> o_rvalid never asserted, o_ready=1, and the next read to the same word misses.

Source files
------------

// File: rtl/subservient_sram_bridge.sv
// -----------------------------------------------------------------------------
// subservient_sram_bridge
//
// Bridges the subservient 8-bit byte-serial SRAM port to a wide dual-port SRAM
// macro (one write port, one read port) with a configurable read latency.
//
// A one-word read buffer serves repeated byte reads of the same word without
// touching the SRAM. With SUBSERVIENT_SRAM_WCOALESCE_EN defined, a one-word
// write buffer merges byte writes to the same word into a single masked word
// write. Without it, every byte write goes straight out as a one-lane masked
// write with the byte replicated across all lanes.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_waddr/i_wdata/i_wen     byte write request
//   i_raddr/i_ren             byte read request
//   i_flush                   write back the coalescing buffer
//   o_ready                   a request can be accepted this cycle
//   o_rdata/o_rvalid          read byte, one-cycle valid pulse
//   o_sram_w*                 SRAM write port (word address, data, byte mask)
//   o_sram_r*, i_sram_rdata   SRAM read port, data RD_LAT cycles after enable
//
// Arbitration: write > flush > read, one request per cycle.
// -----------------------------------------------------------------------------
module subservient_sram_bridge #(
    parameter int MEM_AW  = 10,
    parameter int SRAM_DW = 32,
    parameter int RD_LAT  = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [MEM_AW-1:0]                      i_waddr,
    input  logic [7:0]                             i_wdata,
    input  logic                                   i_wen,
    input  logic [MEM_AW-1:0]                      i_raddr,
    input  logic                                   i_ren,
    input  logic                                   i_flush,
    output logic                                   o_ready,
    output logic [7:0]                             o_rdata,
    output logic                                   o_rvalid,
    output logic [MEM_AW-$clog2(SRAM_DW/8)-1:0]    o_sram_waddr,
    output logic [SRAM_DW-1:0]                     o_sram_wdata,
    output logic [SRAM_DW/8-1:0]                   o_sram_wmask,
    output logic                                   o_sram_wen,
    output logic [MEM_AW-$clog2(SRAM_DW/8)-1:0]    o_sram_raddr,
    output logic                                   o_sram_ren,
    input  logic [SRAM_DW-1:0]                     i_sram_rdata
);
    localparam int BPW = SRAM_DW / 8;
    localparam int LW  = $clog2(BPW);
    localparam int WAW = MEM_AW - LW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FILL  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               rbuf_valid_q, rbuf_valid_d;
    logic [WAW-1:0]     rbuf_word_q, rbuf_word_d;
    logic [SRAM_DW-1:0] rbuf_data_q, rbuf_data_d;
    logic [LW-1:0]      miss_lane_q, miss_lane_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               sram_wen_q, sram_wen_d;
    logic [WAW-1:0]     sram_waddr_q, sram_waddr_d;
    logic [SRAM_DW-1:0] sram_wdata_q, sram_wdata_d;
    logic [BPW-1:0]     sram_wmask_q, sram_wmask_d;
    logic               sram_ren_q, sram_ren_d;
    logic [WAW-1:0]     sram_raddr_q, sram_raddr_d;

    logic [WAW-1:0]     w_word, r_word;
    logic [LW-1:0]      w_lane, r_lane;
    logic               acc_w, acc_f, acc_r;
    logic [BPW-1:0]     w_lane_sel;
    logic [SRAM_DW-1:0] w_bits;     // bit-level mask of the write lane
    logic [SRAM_DW-1:0] w_rep;      // write byte replicated on every lane
    logic [SRAM_DW-1:0] fill_data;  // SRAM word with pending write bytes on top

    assign w_word = i_waddr[MEM_AW-1:LW];
    assign w_lane = i_waddr[LW-1:0];
    assign r_word = i_raddr[MEM_AW-1:LW];
    assign r_lane = i_raddr[LW-1:0];

    // Ready is simply "FSM idle": writes and hits never stall.
    assign o_ready = (state_q == S_IDLE);
    assign acc_w   = o_ready & i_wen;
    assign acc_f   = o_ready & i_flush & ~i_wen;
    assign acc_r   = o_ready & i_ren & ~i_wen & ~i_flush;

    assign w_lane_sel = {{(BPW-1){1'b0}}, 1'b1} << w_lane;

    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_lane
            assign w_bits[gi*8 +: 8] = {8{w_lane_sel[gi]}};
            assign w_rep[gi*8 +: 8]  = i_wdata;
        end
    endgenerate

`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
    logic               wbuf_valid_q, wbuf_valid_d;
    logic [WAW-1:0]     wbuf_word_q, wbuf_word_d;
    logic [SRAM_DW-1:0] wbuf_data_q, wbuf_data_d;
    logic [BPW-1:0]     wbuf_mask_q, wbuf_mask_d;
    logic               fill_hit;

    // The write buffer cannot change while a miss is in flight, so the bytes
    // it holds for the missed word are newer than the SRAM copy.
    assign fill_hit = wbuf_valid_q && (wbuf_word_q == sram_raddr_q);

    generate
        for (gi = 0; gi < BPW; gi++) begin : g_fill
            assign fill_data[gi*8 +: 8] = (fill_hit && wbuf_mask_q[gi]) ?
                                          wbuf_data_q[gi*8 +: 8] : i_sram_rdata[gi*8 +: 8];
        end
    endgenerate
`else
    assign fill_data = i_sram_rdata;
`endif

    always_comb begin
        state_d      = state_q;
        rbuf_valid_d = rbuf_valid_q;
        rbuf_word_d  = rbuf_word_q;
        rbuf_data_d  = rbuf_data_q;
        miss_lane_d  = miss_lane_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        sram_wen_d   = 1'b0;
        sram_waddr_d = sram_waddr_q;
        sram_wdata_d = sram_wdata_q;
        sram_wmask_d = sram_wmask_q;
        sram_ren_d   = 1'b0;
        sram_raddr_d = sram_raddr_q;
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
        wbuf_valid_d = wbuf_valid_q;
        wbuf_word_d  = wbuf_word_q;
        wbuf_data_d  = wbuf_data_q;
        wbuf_mask_d  = wbuf_mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (acc_w) begin
                    // Keep the read buffer coherent with every accepted write.
                    if (rbuf_valid_q && (rbuf_word_q == w_word))
                        rbuf_data_d = (rbuf_data_q & ~w_bits) | (w_rep & w_bits);
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
                    if (wbuf_valid_q && (wbuf_word_q != w_word)) begin
                        sram_wen_d   = 1'b1;
                        sram_waddr_d = wbuf_word_q;
                        sram_wdata_d = wbuf_data_q;
                        sram_wmask_d = wbuf_mask_q;
                    end
                    if (wbuf_valid_q && (wbuf_word_q == w_word)) begin
                        wbuf_data_d = (wbuf_data_q & ~w_bits) | (w_rep & w_bits);
                        wbuf_mask_d = wbuf_mask_q | w_lane_sel;
                    end else begin
                        wbuf_valid_d = 1'b1;
                        wbuf_word_d  = w_word;
                        wbuf_data_d  = w_rep;
                        wbuf_mask_d  = w_lane_sel;
                    end
`else
                    sram_wen_d   = 1'b1;
                    sram_waddr_d = w_word;
                    sram_wdata_d = w_rep;
                    sram_wmask_d = w_lane_sel;
`endif
                end else if (acc_f) begin
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
                    if (wbuf_valid_q) begin
                        sram_wen_d   = 1'b1;
                        sram_waddr_d = wbuf_word_q;
                        sram_wdata_d = wbuf_data_q;
                        sram_wmask_d = wbuf_mask_q;
                        wbuf_valid_d = 1'b0;
                        wbuf_mask_d  = '0;
                    end
`endif
                end else if (acc_r) begin
                    if (rbuf_valid_q && (rbuf_word_q == r_word)) begin
                        rvalid_d = 1'b1;
                        rdata_d  = rbuf_data_q[{r_lane, 3'b000} +: 8];
                    end else begin
                        sram_ren_d   = 1'b1;
                        sram_raddr_d = r_word;
                        miss_lane_d  = r_lane;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = (RD_LAT > 1) ? S_WAIT : S_FILL;
            S_WAIT:  state_d = S_FILL;
            default: begin
                // FILL: read data is on i_sram_rdata this cycle.
                rbuf_valid_d = 1'b1;
                rbuf_word_d  = sram_raddr_q;
                rbuf_data_d  = fill_data;
                rvalid_d     = 1'b1;
                rdata_d      = fill_data[{miss_lane_q, 3'b000} +: 8];
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            rbuf_valid_q <= 1'b0;
            rbuf_word_q  <= '0;
            rbuf_data_q  <= '0;
            miss_lane_q  <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            sram_wen_q   <= 1'b0;
            sram_waddr_q <= '0;
            sram_wdata_q <= '0;
            sram_wmask_q <= '0;
            sram_ren_q   <= 1'b0;
            sram_raddr_q <= '0;
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
            wbuf_valid_q <= 1'b0;
            wbuf_word_q  <= '0;
            wbuf_data_q  <= '0;
            wbuf_mask_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rbuf_valid_q <= rbuf_valid_d;
            rbuf_word_q  <= rbuf_word_d;
            rbuf_data_q  <= rbuf_data_d;
            miss_lane_q  <= miss_lane_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            sram_wen_q   <= sram_wen_d;
            sram_waddr_q <= sram_waddr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_wmask_q <= sram_wmask_d;
            sram_ren_q   <= sram_ren_d;
            sram_raddr_q <= sram_raddr_d;
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_word_q  <= wbuf_word_d;
            wbuf_data_q  <= wbuf_data_d;
            wbuf_mask_q  <= wbuf_mask_d;
`endif
        end
    end

    assign o_rdata      = rdata_q;
    assign o_rvalid     = rvalid_q;
    assign o_sram_wen   = sram_wen_q;
    assign o_sram_waddr = sram_waddr_q;
    assign o_sram_wdata = sram_wdata_q;
    assign o_sram_wmask = sram_wmask_q;
    assign o_sram_ren   = sram_ren_q;
    assign o_sram_raddr = sram_raddr_q;

endmodule

// File: tb/tb_subservient_sram_bridge.sv
`timescale 1ns/1ps
module tb_subservient_sram_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // ---------------- instance A: 32-bit words, latency 1 ----------------
    logic [9:0]  a_waddr = '0, a_raddr = '0;
    logic [7:0]  a_wdata = '0;
    logic        a_wen = 1'b0, a_ren = 1'b0, a_flush = 1'b0;
    logic        a_ready, a_rvalid;
    logic [7:0]  a_rdata;
    logic [7:0]  a_swaddr, a_sraddr;
    logic [31:0] a_swdata;
    logic [31:0] a_srdata = '0;
    logic [3:0]  a_swmask;
    logic        a_swen, a_sren;

    subservient_sram_bridge #(.MEM_AW(10), .SRAM_DW(32), .RD_LAT(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_waddr(a_waddr), .i_wdata(a_wdata), .i_wen(a_wen),
        .i_raddr(a_raddr), .i_ren(a_ren), .i_flush(a_flush),
        .o_ready(a_ready), .o_rdata(a_rdata), .o_rvalid(a_rvalid),
        .o_sram_waddr(a_swaddr), .o_sram_wdata(a_swdata), .o_sram_wmask(a_swmask),
        .o_sram_wen(a_swen), .o_sram_raddr(a_sraddr), .o_sram_ren(a_sren),
        .i_sram_rdata(a_srdata)
    );

    // ---------------- instance B: 64-bit words, latency 2 ----------------
    logic [9:0]  b_raddr = '0;
    logic [9:0]  b_waddr = '0;
    logic [7:0]  b_wdata = '0;
    logic        b_wen = 1'b0, b_ren = 1'b0, b_flush = 1'b0;
    logic        b_ready, b_rvalid;
    logic [7:0]  b_rdata;
    logic [6:0]  b_swaddr, b_sraddr;
    logic [63:0] b_swdata;
    logic [7:0]  b_swmask;
    logic        b_swen, b_sren;
    logic [63:0] b_pipe = '0, b_srdata = '0;

    subservient_sram_bridge #(.MEM_AW(10), .SRAM_DW(64), .RD_LAT(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_waddr(b_waddr), .i_wdata(b_wdata), .i_wen(b_wen),
        .i_raddr(b_raddr), .i_ren(b_ren), .i_flush(b_flush),
        .o_ready(b_ready), .o_rdata(b_rdata), .o_rvalid(b_rvalid),
        .o_sram_waddr(b_swaddr), .o_sram_wdata(b_swdata), .o_sram_wmask(b_swmask),
        .o_sram_wen(b_swen), .o_sram_raddr(b_sraddr), .o_sram_ren(b_sren),
        .i_sram_rdata(b_srdata)
    );

    function automatic logic [31:0] init_a(input int w);
        if (w == 1)  return 32'h44332211;
        if (w == 12) return 32'h00000000;
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [63:0] init_b(input int w);
        return {init_a(w + 300), init_a(w + 600)};
    endfunction

    // SRAM macro models
    logic [31:0] mem_a [256];
    logic        mem_a_loaded = 1'b0;
    int          ren_cnt_a = 0;
    always @(posedge clk) begin
        if (!mem_a_loaded) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_a(i);
            mem_a_loaded <= 1'b1;
        end
        if (a_sren) begin
            a_srdata  <= mem_a[a_sraddr];
            ren_cnt_a <= ren_cnt_a + 1;
        end
        if (a_swen)
            for (int b = 0; b < 4; b++)
                if (a_swmask[b]) mem_a[a_swaddr][b*8 +: 8] <= a_swdata[b*8 +: 8];
    end

    always @(posedge clk) begin
        b_pipe   <= init_b(int'(b_sraddr));
        b_srdata <= b_pipe;
    end

    // Reference model: byte-addressed memory contents as the core sees them
    logic [7:0] gold [1024];

    // Read-buffer and write-buffer occupancy, tracked at word level
    bit         rb_valid;
    logic [7:0] rb_word;
    bit         pend_valid;
    logic [7:0] pend_word;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        int k;
        k = 0;
        while (a_ready !== 1'b1 && k < 20) begin tick(); k++; end
        if (a_ready !== 1'b1) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL ready_timeout: o_ready=%b required 1", a_ready);
        end
    endtask

    task automatic rd_a(input logic [9:0] addr, output logic [7:0] d, output int lat,
                        output int rens, output logic ren_t1);
        int r0;
        wait_ready_a();
        r0 = ren_cnt_a;
        a_raddr = addr;
        a_ren   = 1'b1;
        tick();
        a_ren  = 1'b0;
        ren_t1 = a_sren;
        lat    = 1;
        while (a_rvalid !== 1'b1 && lat < 10) begin tick(); lat++; end
        d    = a_rdata;
        rens = ren_cnt_a - r0;
        $display("rd  addr=%03h data=%02h lat=%0d", addr, d, lat);
    endtask

    task automatic wr_a(input logic [9:0] addr, input logic [7:0] d);
        wait_ready_a();
        a_waddr = addr;
        a_wdata = d;
        a_wen   = 1'b1;
        tick();
        a_wen = 1'b0;
        gold[addr] = d;
        $display("wr  addr=%03h data=%02h sram_wen=%b", addr, d, a_swen);
    endtask

    task automatic fl_a();
        wait_ready_a();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        $display("fl  sram_wen=%b", a_swen);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        cmp_cnt++; if (a_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready: got %b required 1", a_ready); end
        cmp_cnt++; if (a_rvalid !== 1'b0 || a_rdata !== 8'h00) begin err_cnt++; $display("FAIL rst_rd: rvalid=%b rdata=%h required 0/00", a_rvalid, a_rdata); end
        cmp_cnt++; if ({a_swen, a_sren, a_swaddr, a_sraddr, a_swdata, a_swmask} !== '0) begin err_cnt++; $display("FAIL rst_sram: wen=%b ren=%b wa=%h ra=%h wd=%h wm=%h required all 0", a_swen, a_sren, a_swaddr, a_sraddr, a_swdata, a_swmask); end
        cmp_cnt++; if (b_ready !== 1'b1 || b_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_b: ready=%b rvalid=%b required 1/0", b_ready, b_rvalid); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_hit_miss();
        logic [7:0] d; int lat, rens; logic r1;
        rd_a(10'h004, d, lat, rens, r1);
        cmp_cnt++; if (r1 !== 1'b1) begin err_cnt++; $display("FAIL miss_ren_t1: got %b required 1", r1); end
        cmp_cnt++; if (lat != 3) begin err_cnt++; $display("FAIL miss_lat: got %0d required 3", lat); end
        cmp_cnt++; if (d !== 8'h11) begin err_cnt++; $display("FAIL miss_data: got %h required 11", d); end
        rd_a(10'h006, d, lat, rens, r1);
        cmp_cnt++; if (lat != 1 || rens != 0) begin err_cnt++; $display("FAIL hit_lat: lat=%0d rens=%0d required 1/0", lat, rens); end
        cmp_cnt++; if (d !== 8'h33) begin err_cnt++; $display("FAIL hit_data: got %h required 33", d); end
        rb_valid = 1'b1; rb_word = 8'd1;
    endtask

    task automatic test_write();
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
        wr_a(10'h010, 8'hAA);
        cmp_cnt++; if (a_swen !== 1'b0) begin err_cnt++; $display("FAIL coal_load: wen=%b required 0", a_swen); end
        wr_a(10'h011, 8'hBB);
        cmp_cnt++; if (a_swen !== 1'b0) begin err_cnt++; $display("FAIL coal_merge: wen=%b required 0", a_swen); end
        wr_a(10'h020, 8'hCC);
        cmp_cnt++;
        if (a_swen !== 1'b1 || a_swaddr !== 8'd4 || a_swmask !== 4'b0011 || a_swdata[15:0] !== 16'hBBAA) begin
            err_cnt++; $display("FAIL coal_evict: wen=%b wa=%0d wm=%b wd=%h required 1/4/0011/xxxxBBAA", a_swen, a_swaddr, a_swmask, a_swdata);
        end
        fl_a();
        cmp_cnt++;
        if (a_swen !== 1'b1 || a_swaddr !== 8'd8 || a_swmask !== 4'b0001 || a_swdata[7:0] !== 8'hCC) begin
            err_cnt++; $display("FAIL coal_flush: wen=%b wa=%0d wm=%b wd=%h required 1/8/0001/xxxxxxCC", a_swen, a_swaddr, a_swmask, a_swdata);
        end
`else
        wr_a(10'h010, 8'hAA);
        cmp_cnt++;
        if (a_swen !== 1'b1 || a_swaddr !== 8'd4 || a_swmask !== 4'b0001 || a_swdata !== 32'hAAAAAAAA) begin
            err_cnt++; $display("FAIL direct_wr0: wen=%b wa=%0d wm=%b wd=%h required 1/4/0001/AAAAAAAA", a_swen, a_swaddr, a_swmask, a_swdata);
        end
        wr_a(10'h023, 8'hCC);
        cmp_cnt++;
        if (a_swen !== 1'b1 || a_swaddr !== 8'd8 || a_swmask !== 4'b1000 || a_swdata !== 32'hCCCCCCCC) begin
            err_cnt++; $display("FAIL direct_wr3: wen=%b wa=%0d wm=%b wd=%h required 1/8/1000/CCCCCCCC", a_swen, a_swaddr, a_swmask, a_swdata);
        end
`endif
        fl_a();
        cmp_cnt++; if (a_swen !== 1'b0) begin err_cnt++; $display("FAIL empty_flush: wen=%b required 0", a_swen); end
    endtask

    task automatic test_merge();
        logic [7:0] d; int lat, rens; logic r1;
        wr_a(10'h031, 8'h5A);
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
        cmp_cnt++; if (a_swen !== 1'b0) begin err_cnt++; $display("FAIL merge_nowr: wen=%b required 0", a_swen); end
`endif
        rd_a(10'h031, d, lat, rens, r1);
        cmp_cnt++; if (d !== 8'h5A || lat != 3) begin err_cnt++; $display("FAIL merge_rd: data=%h lat=%0d required 5A/3", d, lat); end
        rd_a(10'h030, d, lat, rens, r1);
        cmp_cnt++; if (d !== gold[10'h030] || lat != 1) begin err_cnt++; $display("FAIL merge_hit: data=%h lat=%0d required %h/1", d, lat, gold[10'h030]); end
    endtask

    task automatic test_priority();
        int lat;
        logic [7:0] exp_wa;
        wait_ready_a();
        a_waddr = 10'h040; a_wdata = 8'h77; a_raddr = 10'h004;
        a_wen = 1'b1; a_flush = 1'b1; a_ren = 1'b1;
        gold[10'h040] = 8'h77;
        tick();
        a_wen = 1'b0;
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
        exp_wa = 8'd12;   // the pending 0x031 byte is evicted
`else
        exp_wa = 8'd16;
`endif
        cmp_cnt++;
        if (a_swen !== 1'b1 || a_swaddr !== exp_wa || a_sren !== 1'b0 || a_rvalid !== 1'b0) begin
            err_cnt++; $display("FAIL prio_write: wen=%b wa=%0d ren=%b rvalid=%b required 1/%0d/0/0", a_swen, a_swaddr, a_sren, a_rvalid, exp_wa);
        end
        tick();
        a_flush = 1'b0;
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
        cmp_cnt++;
        if (a_swen !== 1'b1 || a_swaddr !== 8'd16 || a_swmask !== 4'b0001 || a_swdata[7:0] !== 8'h77) begin
            err_cnt++; $display("FAIL prio_flush: wen=%b wa=%0d wm=%b wd=%h required 1/16/0001/xxxxxx77", a_swen, a_swaddr, a_swmask, a_swdata);
        end
`else
        cmp_cnt++; if (a_swen !== 1'b0) begin err_cnt++; $display("FAIL prio_flush: wen=%b required 0", a_swen); end
`endif
        cmp_cnt++; if (a_sren !== 1'b0) begin err_cnt++; $display("FAIL prio_rd_held: ren=%b required 0", a_sren); end
        tick();
        a_ren = 1'b0;
        cmp_cnt++; if (a_sren !== 1'b1 || a_sraddr !== 8'd1) begin err_cnt++; $display("FAIL prio_rd: ren=%b ra=%0d required 1/1", a_sren, a_sraddr); end
        lat = 0;
        while (a_rvalid !== 1'b1 && lat < 10) begin tick(); lat++; end
        cmp_cnt++; if (lat != 2 || a_rdata !== 8'h11) begin err_cnt++; $display("FAIL prio_rdata: wait=%0d data=%h required 2/11", lat, a_rdata); end
        rb_valid = 1'b1; rb_word = 8'd1;
        pend_valid = 1'b0;
    endtask

    task automatic test_random();
        int op, lat, rens;
        logic [9:0] addr;
        logic [7:0] d;
        logic r1;
        bit hit, exp_wen;
        for (int n = 0; n < 400; n++) begin
            op   = int'($urandom_range(0, 9));
            addr = 10'($urandom_range(0, 127));
            if (op < 4) begin
                d = 8'($urandom);
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
                exp_wen = pend_valid && (pend_word != addr[9:2]);
                wr_a(addr, d);
                cmp_cnt++;
                if (a_swen !== exp_wen || (exp_wen && a_swaddr !== pend_word)) begin
                    err_cnt++; $display("FAIL rnd_wr: wen=%b wa=%0d required %b/%0d", a_swen, a_swaddr, exp_wen, pend_word);
                end
                pend_valid = 1'b1; pend_word = addr[9:2];
`else
                wr_a(addr, d);
                cmp_cnt++;
                if (a_swen !== 1'b1 || a_swaddr !== addr[9:2] || a_swmask !== (4'b0001 << addr[1:0]) || a_swdata !== {4{d}}) begin
                    err_cnt++; $display("FAIL rnd_wr: wen=%b wa=%0d wm=%b wd=%h required 1/%0d/lane%0d/%h", a_swen, a_swaddr, a_swmask, a_swdata, addr[9:2], addr[1:0], {4{d}});
                end
`endif
            end else if (op == 4) begin
`ifdef SUBSERVIENT_SRAM_WCOALESCE_EN
                exp_wen = pend_valid;
`else
                exp_wen = 1'b0;
`endif
                fl_a();
                cmp_cnt++; if (a_swen !== exp_wen) begin err_cnt++; $display("FAIL rnd_fl: wen=%b required %b", a_swen, exp_wen); end
                pend_valid = 1'b0;
            end else begin
                hit = rb_valid && (rb_word == addr[9:2]);
                rd_a(addr, d, lat, rens, r1);
                cmp_cnt++; if (d !== gold[addr]) begin err_cnt++; $display("FAIL rnd_rd_data: addr=%h got %h required %h", addr, d, gold[addr]); end
                cmp_cnt++; if (lat != (hit ? 1 : 3)) begin err_cnt++; $display("FAIL rnd_rd_lat: addr=%h got %0d required %0d", addr, lat, hit ? 1 : 3); end
                rb_valid = 1'b1; rb_word = addr[9:2];
            end
        end
    endtask

    task automatic test_final_mem();
        logic [31:0] exp;
        fl_a();
        tick();
        for (int w = 0; w < 256; w++) begin
            exp = {gold[4*w+3], gold[4*w+2], gold[4*w+1], gold[4*w]};
            cmp_cnt++;
            if (mem_a[w] !== exp) begin err_cnt++; $display("FAIL mem_word: word=%0d got %h required %h", w, mem_a[w], exp); end
        end
    endtask

    task automatic test_lat2();
        logic [63:0] exp;
        exp = init_b(1);
        b_raddr = 10'h00C; b_ren = 1'b1;
        tick();
        b_ren = 1'b0;
        cmp_cnt++; if (b_ready !== 1'b0 || b_sren !== 1'b1 || b_sraddr !== 7'd1) begin err_cnt++; $display("FAIL l2_t1: ready=%b ren=%b ra=%0d required 0/1/1", b_ready, b_sren, b_sraddr); end
        tick();
        cmp_cnt++; if (b_ready !== 1'b0 || b_sren !== 1'b0) begin err_cnt++; $display("FAIL l2_t2: ready=%b ren=%b required 0/0", b_ready, b_sren); end
        tick();
        cmp_cnt++; if (b_ready !== 1'b0 || b_rvalid !== 1'b0) begin err_cnt++; $display("FAIL l2_t3: ready=%b rvalid=%b required 0/0", b_ready, b_rvalid); end
        tick();
        cmp_cnt++; if (b_ready !== 1'b1 || b_rvalid !== 1'b1 || b_rdata !== exp[39:32]) begin err_cnt++; $display("FAIL l2_t4: ready=%b rvalid=%b data=%h required 1/1/%h", b_ready, b_rvalid, b_rdata, exp[39:32]); end
        $display("rdB addr=00c data=%02h", b_rdata);
        b_raddr = 10'h00F; b_ren = 1'b1;
        tick();
        b_ren = 1'b0;
        cmp_cnt++; if (b_rvalid !== 1'b1 || b_sren !== 1'b0 || b_rdata !== exp[63:56]) begin err_cnt++; $display("FAIL l2_hit: rvalid=%b ren=%b data=%h required 1/0/%h", b_rvalid, b_sren, b_rdata, exp[63:56]); end
        $display("rdB addr=00f data=%02h", b_rdata);
    endtask

    task automatic test_reset_miss();
        logic [7:0] d; int lat, rens, seen; logic r1;
        wait_ready_a();
        a_raddr = 10'h100; a_ren = 1'b1;
        tick();
        a_ren = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        cmp_cnt++; if (a_ready !== 1'b1 || a_sren !== 1'b0) begin err_cnt++; $display("FAIL rm_async: ready=%b ren=%b required 1/0", a_ready, a_sren); end
        seen = 0;
        repeat (3) begin tick(); if (a_rvalid === 1'b1) seen++; end
        rst_n = 1'b1;
        repeat (5) begin tick(); if (a_rvalid === 1'b1) seen++; end
        cmp_cnt++; if (seen != 0) begin err_cnt++; $display("FAIL rm_no_rvalid: rvalid cycles=%0d required 0", seen); end
        cmp_cnt++; if (a_ready !== 1'b1) begin err_cnt++; $display("FAIL rm_ready: got %b required 1", a_ready); end
        // buffered bytes are discarded by reset; the SRAM is the truth now
        for (int a = 0; a < 1024; a++) gold[a] = mem_a[a / 4][(a % 4) * 8 +: 8];
        rd_a(10'h100, d, lat, rens, r1);
        cmp_cnt++; if (lat != 3 || rens != 1 || d !== gold[10'h100]) begin err_cnt++; $display("FAIL rm_reread: lat=%0d rens=%0d data=%h required 3/1/%h", lat, rens, d, gold[10'h100]); end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) gold[a] = init_a(a / 4) >> ((a % 4) * 8);
        rb_valid = 1'b0; rb_word = '0; pend_valid = 1'b0; pend_word = '0;
        test_reset();
        test_read_hit_miss();
        test_write();
        test_merge();
        test_priority();
        test_random();
        test_final_mem();
        test_lat2();
        test_reset_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
